// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: state encodings and word size.
package data_mem_responder_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_e;

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word-addressed storage: synchronous write port, combinational read port, no reset.
module dmr_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_SIZE,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Commit writes on the rising edge; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data port: one request at a time,
// fixed-latency single-cycle response pulse, sticky protocol-error flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_SIZE,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2   // 1..15, bounded by the 4-bit counter
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [15:0]           req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_is_read,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = 4;

  dmr_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  is_read_q, is_read_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  one_req;
  logic                  accept;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Upper address bits alias onto the array; deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:ADDR_WIDTH];

  assign one_req = req_read ^ req_write;
  assign accept  = (state_q == DMR_IDLE) && one_req;

  // Writes commit on the accept edge so a following read always sees them.
  dmr_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept && req_write),
    .waddr (req_addr[ADDR_WIDTH-1:0]),
    .wdata (req_wdata),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  // Next-state: accept/error in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      DMR_IDLE: begin
        if (req_read && req_write) begin
          err_d = 1'b1;
        end else if (one_req) begin
          addr_d    = req_addr[ADDR_WIDTH-1:0];
          is_read_d = req_read;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = DMR_WAIT;
        end
      end
      DMR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMR_RESP;
          // Sample the array on entry to RESP so earlier writes are visible.
          if (is_read_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMR_RESP: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  // State and response registers; reset abandons any pending transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DMR_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Outputs come from registers/state only; nothing passes through from req_*.
  assign req_ready    = (state_q == DMR_IDLE);
  assign busy         = (state_q == DMR_WAIT) || (state_q == DMR_RESP);
  assign resp_valid   = (state_q == DMR_RESP);
  assign resp_is_read = (state_q == DMR_RESP) && is_read_q;
  assign resp_rdata   = rdata_q;
  assign err          = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined TSC core's data port. The MEM stage issues the initiator signals `mem_read`/`mem_write`; this block is the other end of that interface.
- Accepts one read or write request at a time and holds an internal word-addressed array.
- Returns a one-cycle response pulse after a fixed, parameterised latency. This lets the core's stall logic be exercised against a non-ideal memory.

Parameters:
- WORD_WIDTH, 16, data word width (TSC word size).
- ADDR_WIDTH, 8, number of low address bits used. Array depth is 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from request acceptance to response. Legal range is 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  1  read request; mirrors the core's `mem_read`.
- req_write  in  1  write request; mirrors the core's `mem_write`.
- req_addr  in  16  word address; only bits [ADDR_WIDTH-1:0] are used.
- req_wdata  in  WORD_WIDTH  write data.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge where ready=1 and exactly one of req_read/req_write=1.
- resp_valid  out  1  one-cycle pulse marking completion of the accepted request.
- resp_is_read  out  1  qualifies resp_valid: 1 = read completion, 0 = write ack.
- resp_rdata  out  WORD_WIDTH  read data; holds its value until the next read response.
- busy  out  1  high in WAIT and RESP.
- err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Interface: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_is_read=0, resp_rdata=0, busy=0, err=0, latency counter=0. Array contents are not affected by reset.
- States: IDLE, WAIT, RESP.
- IDLE, valid request: on an edge with exactly one request bit high, the block latches address, type and data. Counter loads LATENCY-1 and state goes to WAIT.
- Write commit: a write updates the array on that same accept edge.
- Read capture: a read captures array[addr] into resp_rdata on the edge entering RESP, so it always reflects every earlier committed write.
- IDLE, both request bits high: not accepted, err<=1, state stays IDLE. Both low: no action.
- WAIT: counter decrements each edge. On the edge where counter==0, state goes to RESP.
- RESP: resp_valid=1 and resp_is_read=latched type for exactly one cycle; next edge returns to IDLE.
- Latency: for a request accepted at edge N, resp_valid rises at edge N+LATENCY and falls at edge N+LATENCY+1.
- Throughput: the earliest next acceptance is edge N+LATENCY+2, i.e. one request per LATENCY+2 cycles.
- Requests while req_ready=0 are ignored, with no error. The core holds its request until it observes acceptance.
- Address wrap: upper address bits are ignored. Address 0x0100 aliases 0x0000 when ADDR_WIDTH=8.
- Outputs resp_valid, resp_is_read, resp_rdata, req_ready and busy are registered or decoded from state only. There is no combinational path from req_* inputs.
- Reset mid-operation: abandons the pending transaction and suppresses its response. A write accepted before reset remains committed.
- Read-after-write to the same address, back-to-back: returns the new data.

Decomposition:
- Shared defines header (alongside the opcode definitions): state encodings DMR_IDLE=2'd0, DMR_WAIT=2'd1, DMR_RESP=2'd2, and the WORD_SIZE constant.
- One natural sub-module, `dmr_mem_array`:
  - synchronous write port (we, waddr, wdata);
  - combinational read port (raddr, rdata);
  - no reset.
- FSM, counter and response registers stay in the top module.

Test Plan:
- Reset, then write 0x1234 to addr 0x05 (LATENCY=2): accept at edge N; resp_valid=1, resp_is_read=0 exactly during cycle N+2..N+3; req_ready=0 and busy=1 from N to N+3.
- Read addr 0x05 immediately after that write completes: resp_is_read=1, resp_rdata=0x1234 at edge M+2; resp_rdata still 0x1234 three cycles later.
- Assert req_read=req_write=1 in IDLE: no acceptance, req_ready stays 1, err=1 and remains 1 after a subsequent legal read; reset clears it.
- Write 0xBEEF to addr 0x0107, then read addr 0x0007: resp_rdata=0xBEEF (alias wrap).
- Accept a read, assert reset one cycle later, release: no resp_valid pulse ever appears; state is IDLE with req_ready=1 in the first cycle after reset deasserts.
- LATENCY=1 build, continuous req_read with addresses 0,1,2: acceptances every 3 cycles, each resp_valid a single cycle, data matches preloaded words.
